// File: rtl/gpio_in_cond.sv
// gpio_in_cond: pad input synchronizer, per-pin debounce filter and edge pulse generator
module gpio_in_cond #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PRESC_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] pin_i,
    input  logic [NUM_PINS-1:0] db_en_i,
    input  logic [CNT_W-1:0]    db_cnt_i,
    input  logic [PRESC_W-1:0]  presc_i,
    output logic [NUM_PINS-1:0] pin_o,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o,
    output logic                tick_o
);
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync;
    logic [NUM_PINS-1:0] pin_nxt;
    logic [PRESC_W-1:0]  pcnt;
    logic                tick;
    logic [CNT_W-1:0]    thr_m1;
    logic [CNT_W-1:0]    cnt     [NUM_PINS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_PINS];

    assign sync   = sync_q[SYNC_STAGES-1];
    // A threshold of 0 behaves like 1, so the accept compare is against thr-1 clamped at 0.
    assign thr_m1 = (db_cnt_i == '0) ? '0 : db_cnt_i - 1'b1;
    // Using >= lets a lowered divisor wrap immediately instead of counting through the range.
    assign tick   = pcnt >= presc_i;

    // Metastability chain on the raw pad inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Shared sample prescaler and its registered debug tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt   <= '0;
            tick_o <= 1'b0;
        end else begin
            pcnt   <= tick ? '0 : pcnt + 1'b1;
            tick_o <= tick;
        end
    end

    // Per-pin bypass or debounce decision; any agreement between sync and pin_o clears the count
    always_comb begin
        pin_nxt = pin_o;
        for (int p = 0; p < NUM_PINS; p++) begin
            cnt_nxt[p] = '0;
            if (!db_en_i[p]) begin
                pin_nxt[p] = sync[p];
            end else if (sync[p] != pin_o[p]) begin
                if (!tick) begin
                    cnt_nxt[p] = cnt[p];
                end else if (cnt[p] >= thr_m1) begin
                    pin_nxt[p] = sync[p];
                end else begin
                    cnt_nxt[p] = cnt[p] + 1'b1;
                end
            end
        end
    end

    // Conditioned levels, debounce counters and edge pulses aligned with the new level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin_o  <= '0;
            rise_o <= '0;
            fall_o <= '0;
            for (int p = 0; p < NUM_PINS; p++) cnt[p] <= '0;
        end else begin
            pin_o  <= pin_nxt;
            rise_o <= pin_nxt & ~pin_o;
            fall_o <= ~pin_nxt & pin_o;
            for (int p = 0; p < NUM_PINS; p++) cnt[p] <= cnt_nxt[p];
        end
    end
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed and randomized checks of gpio_in_cond against a behavioural model
module tb_gpio_in_cond;
    localparam int N  = 8;
    localparam int S  = 2;
    localparam int CW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  pin_i, db_en_i;
    logic [CW-1:0] db_cnt_i;
    logic [PW-1:0] presc_i;
    logic [N-1:0]  pin_o, rise_o, fall_o;
    logic          tick_o;

    int vectors = 0;
    int miscompares = 0;

    // Model: pad history (newest first), conditioned level, mismatched-tick run length per pin
    logic [N-1:0] m_hist [$];
    logic [N-1:0] m_pin, m_rise, m_fall;
    logic         m_tick;
    int           m_since;
    int           m_run [N];

    gpio_in_cond #(.NUM_PINS(N), .SYNC_STAGES(S), .CNT_W(CW), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .pin_i(pin_i), .db_en_i(db_en_i), .db_cnt_i(db_cnt_i),
        .presc_i(presc_i), .pin_o(pin_o), .rise_o(rise_o), .fall_o(fall_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    // Advance model and DUT by one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        logic [N-1:0] sv, np;
        bit tk;
        int thr;
        if (!rst_n) begin
            m_hist = {};
            for (int i = 0; i < S; i++) m_hist.push_back(N'(0));
            m_pin = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_since = 0;
            for (int p = 0; p < N; p++) m_run[p] = 0;
        end else begin
            sv  = m_hist[S-1];
            tk  = m_since >= int'(presc_i);
            thr = (db_cnt_i == 0) ? 1 : int'(db_cnt_i);
            np  = m_pin;
            for (int p = 0; p < N; p++) begin
                if (!db_en_i[p]) begin
                    np[p] = sv[p];
                    m_run[p] = 0;
                end else if (sv[p] == m_pin[p]) begin
                    m_run[p] = 0;
                end else if (tk) begin
                    m_run[p]++;
                    if (m_run[p] >= thr) begin
                        np[p] = sv[p];
                        m_run[p] = 0;
                    end
                end
            end
            m_rise  = np & ~m_pin;
            m_fall  = ~np & m_pin;
            m_pin   = np;
            m_tick  = tk;
            m_since = tk ? 0 : m_since + 1;
            m_hist.push_front(pin_i);
            void'(m_hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pin_i = 8'hFF; db_en_i = '0; db_cnt_i = '0; presc_i = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if ({pin_o, rise_o, fall_o, tick_o} !== 25'd0) begin
                miscompares++;
                $display("FAIL reset_hold k=%0d: pin=%h rise=%h fall=%h tick=%b want all 0", k, pin_o, rise_o, fall_o, tick_o);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (rise_o !== (k == 3 ? 8'hFF : 8'h00) || pin_o !== (k >= 3 ? 8'hFF : 8'h00)) begin
                miscompares++;
                $display("FAIL reset_release k=%0d: pin=%h rise=%h", k, pin_o, rise_o);
            end
            vectors++;
            if ({pin_o, rise_o, fall_o, tick_o} !== {m_pin, m_rise, m_fall, m_tick}) begin
                miscompares++;
                $display("FAIL reset_model k=%0d: dut %h/%h/%h/%b model %h/%h/%h/%b", k, pin_o, rise_o, fall_o, tick_o, m_pin, m_rise, m_fall, m_tick);
            end
        end
    endtask

    task automatic test_bypass();
        int falls = 0;
        pin_i = 8'h00;
        repeat (5) step();
        pin_i = 8'h08;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (pin_o[3] !== (k >= 3) || rise_o[3] !== (k == 3)) begin
                miscompares++;
                $display("FAIL bypass_rise k=%0d: pin3=%b rise3=%b", k, pin_o[3], rise_o[3]);
            end
        end
        pin_i = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            step();
            falls += int'(fall_o[3]);
            vectors++;
            if ({pin_o, rise_o, fall_o, tick_o} !== {m_pin, m_rise, m_fall, m_tick}) begin
                miscompares++;
                $display("FAIL bypass_model k=%0d: dut %h/%h/%h/%b model %h/%h/%h/%b", k, pin_o, rise_o, fall_o, tick_o, m_pin, m_rise, m_fall, m_tick);
            end
        end
        vectors++;
        if (falls != 1) begin
            miscompares++;
            $display("FAIL bypass_fall_count: got %0d want 1", falls);
        end
    endtask

    task automatic test_debounce_accept();
        db_en_i = 8'h01; presc_i = '0; db_cnt_i = 8'd4; pin_i = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (pin_o[0] !== (k >= 6) || rise_o[0] !== (k == 6)) begin
                miscompares++;
                $display("FAIL debounce_accept k=%0d: pin0=%b rise0=%b", k, pin_o[0], rise_o[0]);
            end
        end
        pin_i = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (pin_o[0] !== (k < 6) || fall_o[0] !== (k == 6)) begin
                miscompares++;
                $display("FAIL debounce_release k=%0d: pin0=%b fall0=%b", k, pin_o[0], fall_o[0]);
            end
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        pin_i = 8'h01;
        repeat (3) step();
        pin_i = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step();
            seen |= rise_o[0] | fall_o[0] | pin_o[0];
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL glitch_short: pin0 or pulse went high, got 1 want 0");
        end
        presc_i = 16'd9;
        for (int t = 0; t < 8; t++) begin
            int len = (t % 2 == 0) ? 35 : 45;
            repeat ($urandom_range(0, 9)) step();
            pin_i = 8'h01;
            for (int k = 0; k < len + 60; k++) begin
                if (k == len) pin_i = 8'h00;
                step();
                vectors++;
                if ({pin_o, rise_o, fall_o, tick_o} !== {m_pin, m_rise, m_fall, m_tick}) begin
                    miscompares++;
                    $display("FAIL glitch_model len=%0d k=%0d: dut %h/%h/%h/%b model %h/%h/%h/%b", len, k, pin_o, rise_o, fall_o, tick_o, m_pin, m_rise, m_fall, m_tick);
                end
            end
        end
    endtask

    task automatic test_prescaler();
        bit found = 1'b0;
        db_en_i = '0; db_cnt_i = 8'd1; presc_i = 16'd3;
        for (int k = 0; k < 12; k++) begin
            step();
            vectors++;
            if (tick_o !== m_tick) begin
                miscompares++;
                $display("FAIL presc_period k=%0d: tick=%b want %b", k, tick_o, m_tick);
            end
        end
        presc_i = 16'd7;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = (m_since == 3);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL presc_align: count never reached 3 within 20 cycles");
        end
        presc_i = 16'd1;
        for (int k = 0; k <= 6; k++) begin
            step();
            vectors++;
            if (tick_o !== (k % 2 == 0)) begin
                miscompares++;
                $display("FAIL presc_lower k=%0d: tick=%b want %b", k, tick_o, k % 2 == 0);
            end
        end
        presc_i = '0; db_en_i = 8'hFF; db_cnt_i = '0; pin_i = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (pin_o !== (k >= 3 ? 8'hFF : 8'h00) || rise_o !== (k == 3 ? 8'hFF : 8'h00)) begin
                miscompares++;
                $display("FAIL thr_zero k=%0d: pin=%h rise=%h", k, pin_o, rise_o);
            end
        end
    endtask

    task automatic test_mode_switch();
        db_en_i = 8'hFF; db_cnt_i = 8'd200; presc_i = '0; pin_i = 8'h00;
        repeat (50) step();
        vectors++;
        if (pin_o !== 8'hFF) begin
            miscompares++;
            $display("FAIL mode_hold: pin=%h want ff", pin_o);
        end
        db_en_i = 8'h00;
        step();
        vectors++;
        if (pin_o !== 8'h00 || fall_o !== 8'hFF || rise_o !== 8'h00) begin
            miscompares++;
            $display("FAIL mode_bypass: pin=%h fall=%h rise=%h want 00/ff/00", pin_o, fall_o, rise_o);
        end
        db_en_i = 8'hFF; db_cnt_i = 8'd3; pin_i = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++;
            if (pin_o !== (k >= 5 ? 8'hFF : 8'h00) || rise_o !== (k == 5 ? 8'hFF : 8'h00)) begin
                miscompares++;
                $display("FAIL mode_reenable k=%0d: pin=%h rise=%h", k, pin_o, rise_o);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 3) == 0) pin_i[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                db_en_i  = N'($urandom);
                presc_i  = PW'($urandom_range(0, 4));
                db_cnt_i = CW'($urandom_range(0, 6));
            end
            step();
            vectors++;
            if ({pin_o, rise_o, fall_o, tick_o} !== {m_pin, m_rise, m_fall, m_tick} || (rise_o & fall_o) !== '0) begin
                miscompares++;
                $display("FAIL random k=%0d: dut %h/%h/%h/%b model %h/%h/%h/%b", k, pin_o, rise_o, fall_o, tick_o, m_pin, m_rise, m_fall, m_tick);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_debounce_accept();
        test_glitch();
        test_prescaler();
        test_mode_switch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
